// File: rtl/ssd_pkg.sv
// Shared seven-segment types, active-low segment patterns and the hex decode function.
package ssd_pkg;

  typedef logic [6:0] seg_t;  // {a,b,c,d,e,f,g}, active-low

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t seg;
    case (hex)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg_c
);

  assign seg_c = hex_to_seg(hex);

endmodule

// File: rtl/ssd_scan_controller.sv
// N-digit multiplexed seven-segment scan driver with frame-synchronous double buffering,
// anode dead-time, per-digit blanking/decimal points and leading-zero suppression.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned SCAN_PERIOD = 100000,
  parameter int unsigned DEAD_CYCLES = 1000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   an_o,
  output seg_t                  seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]          slot_cnt;
  logic [IDX_W-1:0]          idx;
  logic [N_DIGITS-1:0][3:0]  pend_nib, act_nib;
  logic [N_DIGITS-1:0]       pend_dp, act_dp, pend_blank, act_blank;

  logic                      slot_wrap_c, frame_bnd_c, vis_c;
  logic [N_DIGITS-1:0]       zob_c, sup_c;
  seg_t                      seg_c;

  assign slot_wrap_c = (slot_cnt == CNT_W'(SCAN_PERIOD - 1));
  assign frame_bnd_c = slot_wrap_c && (idx == IDX_W'(N_DIGITS - 1));

  // Slot timer and digit index
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap_c) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // Double buffer: a load landing on the boundary bypasses pending straight into active
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_nib   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_nib    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (load) begin
        pend_nib   <= digits_i;
        pend_dp    <= dp_i;
        pend_blank <= blank_i;
      end
      if (frame_bnd_c) begin
        act_nib   <= load ? digits_i : pend_nib;
        act_dp    <= load ? dp_i     : pend_dp;
        act_blank <= load ? blank_i  : pend_blank;
      end
    end
  end

  // Leading-zero mask: blanked digits count as leading, digit 0 always shown
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_lz
    assign zob_c[g] = (act_nib[g] == 4'h0) | act_blank[g];
    if (g == 0) begin : g_d0
      assign sup_c[g] = 1'b0;
    end else begin : g_dk
      assign sup_c[g] = lz_en & (&zob_c[N_DIGITS-1:g]);
    end
  end

  assign vis_c = ~act_blank[idx] & ~sup_c[idx] & (slot_cnt >= CNT_W'(DEAD_CYCLES));

  hex_to_ssd u_hex_to_ssd (
    .hex   (act_nib[idx]),
    .seg_c (seg_c)
  );

  // Registered pin drivers
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      an_o    <= '1;
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      an_o    <= vis_c ? ~(N_DIGITS'(1) << idx) : '1;
      seg_o   <= vis_c ? seg_c : SEG_BLANK;
      dp_o    <= ~(vis_c & act_dp[idx]);
      frame_o <= frame_bnd_c;
    end
  end

endmodule
